// File: rtl/store_rmw_unit_pkg.sv
// MEM-stage store definitions shared by the store RMW unit.
// Size encodings, state encoding and the request legality check.
package store_rmw_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  function automatic logic req_bad(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      SZ_ILL:  bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_rmw_unit_byte_lane_merge.sv
// Inserts a byte or halfword into a 32-bit word at the addressed lane.
// Lane order is selectable between little- and big-endian.
module byte_lane_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        big_i,
  output logic [31:0] merged_o
);

  logic [1:0] lane;

  always_comb begin
    merged_o = old_word_i;
    // big-endian byte lane index is 3-offset
    lane = big_i ? ~off_i : off_i;
    case (size_i)
      SZ_BYTE: merged_o[{lane, 3'b000} +: 8] = new_data_i[7:0];
      SZ_HALF: begin
        if (off_i[1] ^ big_i) begin
          merged_o[31:16] = new_data_i[15:0];
        end else begin
          merged_o[15:0] = new_data_i[15:0];
        end
      end
      SZ_WORD: merged_o = new_data_i;
      default: merged_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Narrows byte/half/word stores onto a word-wide memory without byte
// enables, using read-modify-write for sub-word stores.
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit ENDIAN_BIG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       data_q;
  logic [31:0]       merge_q;
  logic [31:0]       merged;
  logic              idle;
  logic              accept;
  logic [ADDR_W-1:0] word_addr;

  assign idle      = (state_q == ST_IDLE);
  assign accept    = req_valid && idle;
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  byte_lane_merge u_merge (
    .old_word_i (mem_rd_data),
    .new_data_i (data_q),
    .size_i     (size_q),
    .off_i      (addr_q[1:0]),
    .big_i      (ENDIAN_BIG),
    .merged_o   (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= req_addr;
        size_q <= req_size;
        data_q <= req_data;
      end
      if (state_q == ST_MERGE) begin
        merge_q <= merged;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad(req_size, req_addr[1:0])) begin
            state_d = ST_ERR;
          end else if (req_size == SZ_WORD) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ:  state_d = ST_MERGE;
      ST_MERGE: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // reset masks strobes so an in-flight WRITE never reaches memory
  always_comb begin
    req_ready    = idle || reset;
    busy         = !idle && !reset;
    done         = 1'b0;
    misalign_err = 1'b0;
    mem_addr     = '0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    mem_wr_data  = '0;
    if (!reset) begin
      case (state_q)
        ST_READ: begin
          mem_rd_en = 1'b1;
          mem_addr  = word_addr;
        end
        ST_WRITE: begin
          mem_wr_en   = 1'b1;
          done        = 1'b1;
          mem_addr    = word_addr;
          mem_wr_data = (size_q == SZ_WORD) ? data_q : merge_q;
        end
        ST_ERR:  misalign_err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Testbench for store_rmw_unit: merge-lane table, directed sequences,
// and randomized stores against a word-array reference memory.
module tb_store_rmw_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_data;

  logic        le_ready, le_busy, le_done, le_err;
  logic [31:0] le_addr, le_wd, le_rd;
  logic        le_rd_en, le_wr_en;
  logic        be_ready, be_busy, be_done, be_err;
  logic [31:0] be_addr, be_wd, be_rd;
  logic        be_rd_en, be_wr_en;

  logic [31:0] mg_old, mg_new, mg_out;
  logic [1:0]  mg_sz, mg_off;
  logic        mg_big;

  logic [31:0] mem0 [0:63];
  logic [31:0] mem1 [0:63];
  logic [31:0] ref0 [0:63];
  logic [31:0] ref1 [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  logic [31:0] wa [0:255];

  logic [9:1]  t_rd, t_wr, t_done, t_err, t_busy, t_rdy, t_both;
  logic [31:0] t_addr [1:9];
  logic [31:0] t_wd0 [1:9];
  logic [31:0] t_wd1 [1:9];

  store_rmw_unit #(.ADDR_W(32), .ENDIAN_BIG(1'b0)) u_le (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_size(req_size),
    .req_addr(req_addr), .req_data(req_data), .req_ready(le_ready),
    .busy(le_busy), .done(le_done), .misalign_err(le_err),
    .mem_addr(le_addr), .mem_rd_en(le_rd_en), .mem_rd_data(le_rd),
    .mem_wr_en(le_wr_en), .mem_wr_data(le_wd)
  );

  store_rmw_unit #(.ADDR_W(32), .ENDIAN_BIG(1'b1)) u_be (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_size(req_size),
    .req_addr(req_addr), .req_data(req_data), .req_ready(be_ready),
    .busy(be_busy), .done(be_done), .misalign_err(be_err),
    .mem_addr(be_addr), .mem_rd_en(be_rd_en), .mem_rd_data(be_rd),
    .mem_wr_en(be_wr_en), .mem_wr_data(be_wd)
  );

  byte_lane_merge u_blm (
    .old_word_i(mg_old), .new_data_i(mg_new), .size_i(mg_sz),
    .off_i(mg_off), .big_i(mg_big), .merged_o(mg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    le_rd <= mem0[le_addr[7:2]];
    be_rd <= mem1[be_addr[7:2]];
    if (pl_en) begin
      mem0[pl_idx] <= pl_val;
      mem1[pl_idx] <= pl_val;
    end else begin
      if (le_wr_en) mem0[le_addr[7:2]] <= le_wd;
      if (be_wr_en) mem1[be_addr[7:2]] <= be_wd;
    end
    if (le_wr_en) begin
      wa[wr_count % 256] <= le_addr;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b11) return 1'b0;
    if (sz == 2'b01) return off[0] == 1'b0;
    if (sz == 2'b10) return off == 2'b00;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old,
      input logic [31:0] d, input logic [1:0] sz, input logic [1:0] off,
      input bit big);
    int pos;
    logic [31:0] m;
    if (sz == 2'b10) return d;
    if (sz == 2'b00) begin
      pos = big ? 3 - int'(off) : int'(off);
      m = 32'hFF << (8 * pos);
      return (old & ~m) | ((d & 32'hFF) << (8 * pos));
    end
    pos = (off[1] != big) ? 2 : 0;
    m = 32'hFFFF << (8 * pos);
    return (old & ~m) | ((d & 32'hFFFF) << (8 * pos));
  endfunction

  function automatic int first_of(input logic [9:1] v, input int n);
    for (int c = 1; c <= n; c++) if (v[c]) return c;
    return 0;
  endfunction

  task automatic record(input int c);
    t_rd[c]   = le_rd_en;
    t_wr[c]   = le_wr_en;
    t_done[c] = le_done;
    t_err[c]  = le_err;
    t_busy[c] = le_busy;
    t_rdy[c]  = le_ready;
    t_both[c] = le_rd_en && le_wr_en;
    t_addr[c] = le_addr;
    t_wd0[c]  = le_wd;
    t_wd1[c]  = be_wd;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref0[idx] = v;
    ref1[idx] = v;
  endtask

  task automatic issue_trace(input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, input int ncyc);
    int g;
    logic [5:0] idx;
    g = 0;
    idx = a[7:2];
    t_rd = '0; t_wr = '0; t_done = '0; t_err = '0;
    t_busy = '0; t_rdy = '0; t_both = '0;
    @(negedge clk);
    while (!le_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("ready_wait", {31'd0, le_ready}, 32'd1);
    req_valid = 1'b1; req_size = sz; req_addr = a; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (is_legal(sz, a[1:0])) begin
      ref0[idx] = ref_merge(ref0[idx], d, sz, a[1:0], 1'b0);
      ref1[idx] = ref_merge(ref1[idx], d, sz, a[1:0], 1'b1);
    end
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      record(c);
    end
  endtask

  typedef struct {
    logic [31:0] old_w;
    logic [31:0] nd;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic        big;
    logic [31:0] exp;
  } mv_t;

  mv_t mv [0:11];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0, fw, fe, fr, bad, acc;
    logic [1:0] rs;
    logic [31:0] ra, rd;
    logic [1:0]  ms [0:2];
    logic [31:0] maddr [0:2];

    reset = 1'b1; req_valid = 1'b0; req_size = '0; req_addr = '0;
    req_data = '0; pl_en = 1'b0; pl_idx = '0; pl_val = '0;

    mv[0]  = '{32'h11223344, 32'h000000AB, 2'b00, 2'd0, 1'b0, 32'h112233AB};
    mv[1]  = '{32'h11223344, 32'h000000AB, 2'b00, 2'd1, 1'b0, 32'h1122AB44};
    mv[2]  = '{32'h11223344, 32'h000000AB, 2'b00, 2'd2, 1'b0, 32'h11AB3344};
    mv[3]  = '{32'h11223344, 32'h000000AB, 2'b00, 2'd3, 1'b0, 32'hAB223344};
    mv[4]  = '{32'h11223344, 32'h000000AB, 2'b00, 2'd0, 1'b1, 32'hAB223344};
    mv[5]  = '{32'h11223344, 32'h000000AB, 2'b00, 2'd3, 1'b1, 32'h112233AB};
    mv[6]  = '{32'h11223344, 32'hFFFFBEEF, 2'b01, 2'd0, 1'b0, 32'h1122BEEF};
    mv[7]  = '{32'h11223344, 32'hFFFFBEEF, 2'b01, 2'd2, 1'b0, 32'hBEEF3344};
    mv[8]  = '{32'h11223344, 32'hFFFFBEEF, 2'b01, 2'd0, 1'b1, 32'hBEEF3344};
    mv[9]  = '{32'h11223344, 32'hFFFFBEEF, 2'b01, 2'd2, 1'b1, 32'h1122BEEF};
    mv[10] = '{32'h11223344, 32'hDEADBEEF, 2'b10, 2'd0, 1'b0, 32'hDEADBEEF};
    mv[11] = '{32'h11223344, 32'h000000AB, 2'b00, 2'd1, 1'b1, 32'h11AB3344};

    for (int i = 0; i < 12; i++) begin
      mg_old = mv[i].old_w; mg_new = mv[i].nd; mg_sz = mv[i].sz;
      mg_off = mv[i].off; mg_big = mv[i].big;
      #1;
      chk($sformatf("merge_%0d", i), mg_out, mv[i].exp);
    end

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, le_ready}, 32'd1);
    chk("rst_outs", {26'd0, le_busy, le_done, le_err, le_rd_en, le_wr_en,
                     |le_addr}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, le_ready}, 32'd1);
    chk("idle_outs", {28'd0, le_busy, le_rd_en, le_wr_en, |le_wd}, 32'd0);

    for (int i = 0; i < 64; i++) preload(6'(i), $urandom);

    // word store
    issue_trace(2'b10, 32'h10, 32'h12345678, 4);
    chk("sw_wr_c1", {31'd0, t_wr[1]}, 32'd1);
    chk("sw_done_c1", {31'd0, t_done[1]}, 32'd1);
    chk("sw_addr", t_addr[1], 32'h10);
    chk("sw_data", t_wd0[1], 32'h12345678);
    chk("sw_no_rd", {28'd0, t_rd[4:1]}, 32'd0);
    chk("sw_ready_c2", {31'd0, t_rdy[2]}, 32'd1);

    // byte store, both lane orders
    preload(6'h04, 32'h11223344);
    issue_trace(2'b00, 32'h13, 32'h000000AB, 4);
    chk("sb_rd_c1", {31'd0, t_rd[1]}, 32'd1);
    chk("sb_rd_addr", t_addr[1], 32'h10);
    chk("sb_wr_c3", {28'd0, t_wr[4:1]}, 32'b0100);
    chk("sb_le_data", t_wd0[3], 32'hAB223344);
    chk("sb_be_data", t_wd1[3], 32'h112233AB);

    // halfword store
    preload(6'h08, 32'hAAAAAAAA);
    issue_trace(2'b01, 32'h22, 32'hFFFFBEEF, 4);
    chk("sh_data", t_wd0[3], 32'hBEEFAAAA);
    chk("sh_addr", t_addr[3], 32'h20);
    chk("sh_busy", {29'd0, t_busy[3:1]}, 32'b111);
    chk("sh_ready", {28'd0, t_rdy[4:1]}, 32'b1000);

    // rejected requests
    ms[0] = 2'b01; maddr[0] = 32'h21;
    ms[1] = 2'b10; maddr[1] = 32'h26;
    ms[2] = 2'b11; maddr[2] = 32'h20;
    for (int i = 0; i < 3; i++) begin
      issue_trace(ms[i], maddr[i], 32'hDEAD0000, 4);
      chk($sformatf("err_pulse_%0d", i), {30'd0, t_err[2:1]}, 32'b01);
      chk($sformatf("err_nomem_%0d", i), {24'd0, t_rd[4:1], t_wr[4:1]}, 32'd0);
      chk($sformatf("err_ready_%0d", i), {31'd0, t_rdy[2]}, 32'd1);
    end

    // reset while in MERGE of a byte store
    @(negedge clk);
    wc0 = wr_count;
    req_valid = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_data = 32'hCD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_abort_ready", {31'd0, le_ready}, 32'd1);
    chk("rst_abort_outs", {29'd0, le_busy, le_rd_en, le_wr_en}, 32'd0);
    chk("rst_abort_mem", le_addr | le_wd, 32'd0);
    repeat (4) @(negedge clk);
    chk("rst_abort_nowr", 32'(wr_count - wc0), 32'd0);
    chk("rst_abort_memword", mem0[4], ref0[4]);
    issue_trace(2'b10, 32'h10, 32'hCAFEF00D, 3);
    chk("post_rst_sw", {t_wr[1], t_wd0[1][30:0]}, {1'b1, 31'h4AFEF00D});

    // back-to-back with valid held
    @(negedge clk);
    wc0 = wr_count;
    acc = 0;
    t_rdy = '0; t_wr = '0; t_both = '0; t_rd = '0;
    req_valid = 1'b1; req_size = 2'b00; req_addr = 32'h31; req_data = 32'h5A;
    @(posedge clk); #1;
    ref0[12] = ref_merge(ref0[12], 32'h5A, 2'b00, 2'd1, 1'b0);
    ref1[12] = ref_merge(ref1[12], 32'h5A, 2'b00, 2'd1, 1'b1);
    req_size = 2'b10; req_addr = 32'h34; req_data = 32'h0BADBEEF;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      record(c);
      if (le_ready && req_valid) begin
        acc = c;
        @(posedge clk); #1;
        req_valid = 1'b0;
      end
    end
    ref0[13] = 32'h0BADBEEF;
    ref1[13] = 32'h0BADBEEF;
    chk("b2b_accept_c", 32'(acc), 32'd4);
    chk("b2b_wr_cycles", {24'd0, t_wr[8:1]}, 32'b00010100);
    chk("b2b_overlap", {24'd0, t_both[8:1]}, 32'd0);
    chk("b2b_nwr", 32'(wr_count - wc0), 32'd2);
    chk("b2b_order0", wa[wc0 % 256], 32'h30);
    chk("b2b_order1", wa[(wc0 + 1) % 256], 32'h34);
    chk("b2b_mem12", mem0[12], ref0[12]);
    chk("b2b_mem13", mem0[13], ref0[13]);

    // randomized stores against the reference memories
    for (int n = 0; n < 80; n++) begin
      rs = 2'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 255));
      rd = $urandom;
      issue_trace(rs, ra, rd, 5);
      fw = first_of(t_wr, 5);
      fe = first_of(t_err, 5);
      fr = first_of(t_rd, 5);
      if (!is_legal(rs, ra[1:0])) begin
        chk("rnd_err", {fe[7:0], fw[7:0], fr[7:0]}, {8'd1, 8'd0, 8'd0});
      end else if (rs == 2'b10) begin
        chk("rnd_sw", {fe[7:0], fw[7:0], fr[7:0]}, {8'd0, 8'd1, 8'd0});
      end else begin
        chk("rnd_sub", {fe[7:0], fw[7:0], fr[7:0]}, {8'd0, 8'd3, 8'd1});
      end
      if (fw != 0) chk("rnd_wr_addr", t_addr[fw], {ra[31:2], 2'b00});
      chk("rnd_mem_le", mem0[ra[7:2]], ref0[ra[7:2]]);
      chk("rnd_mem_be", mem1[ra[7:2]], ref1[ra[7:2]]);
    end

    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (mem0[i] !== ref0[i] || mem1[i] !== ref1[i]) bad++;
    end
    chk("final_mem_words_bad", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Write-side counterpart of the load/immediate extension path in the MEM stage.
- Takes a store request (byte, halfword or word, 32-bit register data) and narrows it into a word-wide data memory that has no byte enables.
- Sub-word stores use read-modify-write: read the word, merge the low byte or halfword of the store data into the addressed lane, write the word back.
- Asserts busy so the hazard unit can stall the pipeline while the unit is working.

Parameters:
- ADDR_W, 32, byte-address width; the memory word address is addr[ADDR_W-1:2].
- ENDIAN_BIG, 0, lane order. 0: offset 0 maps to bits [7:0]. 1: offset 0 maps to bits [31:24].

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  store request present.
- req_size  in  2  00 byte (sb), 01 halfword (sh), 10 word (sw), 11 illegal.
- req_addr  in  ADDR_W  byte address.
- req_data  in  32  store data; low byte or low halfword is used for sub-word stores.
- req_ready  out  1  unit can accept a request.
- busy  out  1  unit is mid-operation; feeds the pipeline stall logic.
- done  out  1  one-cycle pulse in the cycle the memory write is issued.
- misalign_err  out  1  one-cycle pulse when a request is rejected.
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits forced to 0).
- mem_rd_en  out  1  read strobe; data returns on mem_rd_data the next cycle.
- mem_rd_data  in  32  read data.
- mem_wr_en  out  1  write strobe, one cycle.
- mem_wr_data  out  32  full word to write.

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- On reset:
  - state goes to IDLE; all registered fields clear to 0.
  - Every output is 0 except req_ready=1.
  - Reset during READ, MERGE or WRITE abandons the operation; no mem_wr_en is issued in the reset cycle or afterwards.
- Handshake:
  - req_ready = (state==IDLE). A request is accepted when req_valid && req_ready; addr, size and data are registered at that edge.
  - A request presented while not ready is ignored. Upstream holds it until accepted; no internal queueing.
  - busy = (state!=IDLE).
- Request check at accept:
  - Rejected when size 01 has addr[0]=1, size 10 has addr[1:0]!=0, or size is 11.
  - Rejected request: next state is ERR. ERR lasts one cycle, pulses misalign_err, makes no memory access, then returns to IDLE.
- State machine: IDLE, READ, MERGE, WRITE, ERR.
  - IDLE -> WRITE on a legal word store.
  - IDLE -> READ on a legal byte or halfword store.
  - IDLE -> ERR on an illegal request.
  - READ: mem_rd_en=1, mem_addr=word address; -> MERGE.
  - MERGE: capture mem_rd_data; replace the selected lane with req_data[7:0] (byte) or req_data[15:0] (half, lane at addr[1]); store the result in the merge register; -> WRITE.
  - WRITE: mem_wr_en=1, done=1, mem_wr_data = merge register (sub-word) or registered data (word); -> IDLE.
- Latency, with cycle 0 = accept edge:
  - Word store writes in cycle 1.
  - Byte or half store writes in cycle 3.
  - The next request can be accepted in the cycle after WRITE or ERR.
- Output timing: memory outputs are 0 except in the cycles listed above. mem_addr holds the word address in READ and WRITE, and is 0 otherwise.
- No combinational path from req_* to mem_* outputs.

Decomposition:
- Shared package (MEM-stage definitions):
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state encoding constants.
- Sub-module byte_lane_merge: combinational.
  - Inputs: old word, new data, size, addr[1:0], endian select.
  - Output: merged word.
  - Tested separately, then instantiated once inside MERGE.

Test Plan:
- sw 0x12345678 at 0x0000_0010 accepted in cycle 0 -> cycle 1: mem_wr_en=1, mem_addr=0x10, mem_wr_data=0x12345678, done=1; no mem_rd_en in any cycle.
- sb 0x000000AB at 0x13, memory word = 0x11223344, little-endian:
  - cycle 1: mem_rd_en, mem_addr=0x10.
  - cycle 3: mem_wr_data=0xAB223344.
  - Repeat with ENDIAN_BIG=1 -> 0x112233AB.
- sh 0xFFFFBEEF at 0x22 with old word 0xAAAAAAAA, little-endian -> write 0xBEEFAAAA at 0x20; busy high in cycles 1-3; req_ready low in cycles 1-3.
- Misalignment: sh at 0x21, sw at 0x26, size 11 -> each gives misalign_err pulse in cycle 1; mem_rd_en and mem_wr_en stay 0; req_ready back to 1 in cycle 2.
- Reset asserted in MERGE of an sb -> no write ever issued; the next cycle shows req_ready=1, busy=0, all mem_* = 0; a following sw completes normally.
- Back-to-back: sb with req_valid held high behind it -> second request accepted only in the cycle after done; two writes in order, with no overlap of read and write.
